// File: rtl/bcd_display_driver.sv
// Binary-to-BCD display stage: sequential double-dabble conversion feeding a multiplexed
// common-anode 7-segment scanner. Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_display_driver #(
  parameter int N           = 16,
  parameter int DIGITS      = 5,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          value,
  input  logic                  value_valid,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     anodes,
  output logic [6:0]            segments
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(N + 1);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LATCH   = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic            busy_r;
  logic [N-1:0]    bin_r;
  logic [BW-1:0]   scratch_r;
  logic [BW-1:0]   adj_s;
  logic [BW+N-1:0] shifted_s;
  logic [CW-1:0]   iter_r;
  logic [BW-1:0]   bcd_r;
  logic [RW-1:0]   ref_r;
  logic [IW-1:0]   idx_r;
  logic [3:0]      digit_s;

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = s[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Active-low patterns, bit order g..a
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  assign adj_s     = add3(scratch_r);
  assign shifted_s = {adj_s, bin_r} << 1'b1;

  // Conversion FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (value_valid) state_s = CONVERT;
        else             state_s = IDLE;
      end
      CONVERT: begin
        if (iter_r == CW'(N - 1)) state_s = LATCH;
        else                      state_s = CONVERT;
      end
      LATCH:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and registered busy flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  // Double-dabble datapath; bcd_r only moves in LATCH so the display never sees partial data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_r     <= '0;
      scratch_r <= '0;
      iter_r    <= '0;
      bcd_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (value_valid) begin
            bin_r     <= value;
            scratch_r <= '0;
            iter_r    <= '0;
          end
        end
        CONVERT: begin
          {scratch_r, bin_r} <= shifted_s;
          iter_r             <= iter_r + CW'(1);
        end
        LATCH:   bcd_r <= scratch_r;
        default: bcd_r <= bcd_r;
      endcase
    end
  end

  // Refresh divider and digit scan index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_r <= '0;
      idx_r <= '0;
    end else if (ref_r == RW'(REFRESH_DIV - 1)) begin
      ref_r <= '0;
      if (idx_r == IW'(DIGITS - 1)) idx_r <= '0;
      else                          idx_r <= idx_r + IW'(1);
    end else begin
      ref_r <= ref_r + RW'(1);
    end
  end

  // Select the nibble currently being scanned
  always_comb begin
    digit_s = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit_s = digit_s | ((idx_r == IW'(i)) ? bcd_r[4*i +: 4] : 4'd0);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic nz_at_or_above_s;

  // A digit is a leading zero when it and every higher digit are zero
  always_comb begin
    nz_at_or_above_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      nz_at_or_above_s = nz_at_or_above_s |
                         ((IW'(i) >= idx_r) && (bcd_r[4*i +: 4] != 4'd0));
    end
  end

  assign segments = ((idx_r != '0) && !nz_at_or_above_s) ? 7'b1111111 : seg7(digit_s);
`else
  assign segments = seg7(digit_s);
`endif

  assign anodes  = ~(DIGITS'(1) << idx_r);
  assign busy    = busy_r;
  assign bcd_out = bcd_r;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Scoreboard bench for bcd_display_driver: expected BCD results are queued at strobe time
// and a monitor checks them when busy falls; scanner outputs are checked against a cycle model.
module tb_bcd_display_driver;

  localparam int N      = 16;
  localparam int DIGITS = 5;
  localparam int RDIV   = 4;
  localparam logic [6:0] SEGTAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        value_valid;
  logic        busy;
  logic [19:0] bcd_out;
  logic [4:0]  anodes;
  logic [6:0]  segments;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [19:0] exp_q[$];
  int          cyc;
  bit          prev_busy;
  int          busy_len;

  bcd_display_driver #(.N(N), .DIGITS(DIGITS), .REFRESH_DIV(RDIV)) dut (
    .clk(clk), .reset(reset), .value(value), .value_valid(value_valid),
    .busy(busy), .bcd_out(bcd_out), .anodes(anodes), .segments(segments)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Clock cycles since reset release; drives the scanner model
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Monitor: on each busy falling edge, check busy length and pop the expected result
  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b0;
      busy_len  = 0;
    end else begin
      if (busy) begin
        busy_len++;
      end else if (prev_busy) begin
        chk("busy_cycles", busy_len, N + 1);
        chk("result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("bcd_out", bcd_out, exp_q.pop_front());
        busy_len = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic strobe(input logic [15:0] v, input bit accept, input logic [19:0] e);
    @(posedge clk); #1;
    value       = v;
    value_valid = 1'b1;
    if (accept) exp_q.push_back(e);
    @(posedge clk); #1;
    value_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #2;
      if (!busy && exp_q.size() == 0) break;
    end
    chk("done_timeout", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_bcd"}, bcd_out, 0);
    chk({tag, "_anodes"}, anodes, 5'b11110);
    chk({tag, "_segments"}, segments, 7'b1000000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          idx;
    logic [4:0]  ea;
    logic [6:0]  es;
    logic [19:0] shown;
    logic [3:0]  d;

    reset       = 1'b1;
    value       = 16'd0;
    value_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);

    // Asynchronous reset mid-operation
    #1 reset = 1'b1;
    #1 check_reset_outputs("reset");
    @(posedge clk); #1 reset = 1'b0;

    strobe(16'd0, 1'b1, 20'h00000);     wait_done();
    strobe(16'd65535, 1'b1, 20'h65535); wait_done();
    strobe(16'd1234, 1'b1, 20'h01234);  wait_done();

    // Second strobe three cycles later, while busy, must be ignored
    strobe(16'd42, 1'b1, 20'h00042);
    repeat (2) @(posedge clk);
    #1 value = 16'd999; value_valid = 1'b1;
    @(posedge clk); #1 value_valid = 1'b0;
    wait_done();

    // Reset during the 8th CONVERT cycle of 500 discards the partial result
    strobe(16'd500, 1'b0, 20'h00000);
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    #1 check_reset_outputs("abort");
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("abort_busy_after", busy, 0);
    chk("abort_bcd_after", bcd_out, 0);
    strobe(16'd500, 1'b1, 20'h00500);   wait_done();

    // Scanner sequence on 0x01234
    strobe(16'd1234, 1'b1, 20'h01234);  wait_done();
    shown = 20'h01234;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #2;
      idx     = (cyc / RDIV) % DIGITS;
      ea      = 5'b11111;
      ea[idx] = 1'b0;
      d       = shown[4*idx +: 4];
      es      = SEGTAB[d];
`ifdef LEADING_ZERO_BLANK_EN
      if (idx == 4) es = 7'b1111111;
`endif
      chk("scan_anodes", anodes, ea);
      chk("scan_segments", segments, es);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_display_driver.md
# bcd_display_driver

Display stage that consumes the binary value produced by the N-bit counter and shows it in decimal on a multiplexed common-anode 7-segment display. A strobed binary input is converted to packed BCD by a sequential shift-and-add-3 (double-dabble) engine. The stored BCD result is then scanned digit by digit onto shared segment lines with a programmable refresh divider.

## Interface
- N, 16: width of binary input `value`.
- DIGITS, 5: number of display digits; must satisfy DIGITS ≥ ceil(N·log10(2)). Smaller values are unsupported.
- REFRESH_DIV, 100000: clock cycles each digit stays lit (≥ 2).

- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- value  in  N  unsigned binary value to display.
- value_valid  in  1  load strobe; sampled only in IDLE.
- busy  out  1  high while a conversion is in progress.
- bcd_out  out  4·DIGITS  registered packed BCD result; digit 0 (units) in bits [3:0].
- anodes  out  DIGITS  active-low digit enables, one-hot; bit i lights digit i.
- segments  out  7  active-low segments; bit0 = a … bit6 = g.

## Operation
- Conversion FSM states:
  - IDLE: `busy`=0. If `value_valid`=1 at an edge, load `value` into the shift register, clear the BCD scratch and iteration counter, and go to CONVERT.
  - CONVERT: one iteration per cycle, N iterations total. Each iteration adds 3 to every scratch nibble ≥ 5, then shifts the {scratch, binary} register left by 1. After the Nth iteration, go to LATCH.
  - LATCH: copy scratch to `bcd_out`; go to IDLE.
- `busy` = (state ≠ IDLE), registered.
- `value_valid` while `busy`=1 is ignored. It is not queued.
- `bcd_out` changes only in LATCH, so the display never shows a partial result.
- Scanner, independent of the FSM:
  - Refresh counter counts 0..REFRESH_DIV−1 and wraps.
  - On wrap, digit index increments modulo DIGITS (DIGITS−1 → 0).
- `anodes` = ~(1 << index). `segments` = 7-seg decode of nibble `index` of `bcd_out`. Both outputs are combinational from registers only.
- Decode patterns (g..a, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Nibbles 10–15 cannot occur and decode to all-off (1111111).
- Reset mid-conversion aborts the conversion and discards the partial result.

## Timing
- Reset values:
  - state IDLE, `busy`=0, `bcd_out`=0.
  - Refresh counter 0, index 0.
  - `anodes` = all ones except bit0 = 0.
  - `segments` = 1000000 (digit '0').
- Acceptance at edge E0 → `busy`=1 after E0.
- Iterations occur at E1..EN; LATCH is entered after EN.
- `bcd_out` is updated and `busy`=0 after edge E(N+1). `busy` is high for exactly N+1 cycles.
- A new `value_valid` is accepted at E(N+1) only if the FSM is in IDLE when sampled, i.e. earliest at E(N+2). A strobe held continuously restarts the conversion every N+2 cycles.
- Each digit is lit for exactly REFRESH_DIV cycles. A full frame takes DIGITS·REFRESH_DIV cycles.
- A `bcd_out` update appears on `segments` in the same cycle; the scan position is not disturbed.

## Configuration
- Macro `LEADING_ZERO_BLANK_EN`:
  - Defined: any digit whose index is above the most-significant nonzero digit is blanked (`segments` = 1111111; the anode still scans). Digit 0 is never blanked, so value 0 shows a single "0".
  - Undefined: all DIGITS are shown, including leading zeros.

## Test plan
- Reset asserted mid-operation: all outputs take their reset values immediately, without waiting for a clock edge.
- value=0, strobe one cycle: `busy` high for 17 cycles (N=16), then `bcd_out`=0x00000.
- value=65535: after 17 cycles, `bcd_out`=0x65535. Also check value=1234 → 0x01234.
- Strobe value=42, then strobe value=999 three cycles later (while busy): `bcd_out`=0x00042; the second strobe is ignored.
- REFRESH_DIV=4, `bcd_out`=0x01234:
  - `anodes` sequence 11110, 11101, 11011, 10111, 01111, 11110…, each held for 4 cycles.
  - `segments` sequence 4, 3, 2, 1, 0.
  - With `LEADING_ZERO_BLANK_EN` defined, digit 4 shows 1111111.
- Reset pulsed at the 8th CONVERT cycle of value=500: `bcd_out` stays 0 and `busy`=0. A new strobe of 500 then yields 0x00500.
